// File: rtl/mux41_rr_arbiter_if.sv
// rtl/mux41_rr_arbiter_if.sv - request/data/grant bundle between requesters and the 4:1 round-robin arbiter (ilock present with MUX41_ARB_LOCK_EN)
interface mux41_rr_arbiter_if #(
    parameter int W = 4
);
    logic [3:0]   ireq;
    logic [W-1:0] ic0;
    logic [W-1:0] ic1;
    logic [W-1:0] ic2;
    logic [W-1:0] ic3;
    logic [3:0]   ogrant;
    logic [1:0]   os;
    logic [W-1:0] oz;
    logic         ovalid;
    logic         obusy;
`ifdef MUX41_ARB_LOCK_EN
    logic         ilock;

    modport master (
        output ireq, ic0, ic1, ic2, ic3, ilock,
        input  ogrant, os, oz, ovalid, obusy
    );
    modport slave (
        input  ireq, ic0, ic1, ic2, ic3, ilock,
        output ogrant, os, oz, ovalid, obusy
    );
`else
    modport master (
        output ireq, ic0, ic1, ic2, ic3,
        input  ogrant, os, oz, ovalid, obusy
    );
    modport slave (
        input  ireq, ic0, ic1, ic2, ic3,
        output ogrant, os, oz, ovalid, obusy
    );
`endif
endinterface

// File: rtl/mux41_rr_arbiter.sv
// rtl/mux41_rr_arbiter.sv - round-robin sequencer sharing one 4:1 W-bit mux; MUX41_ARB_LOCK_EN adds ilock grant extension
module mux41_rr_arbiter #(
    parameter int W    = 4,
    parameter int HOLD = 4
) (
    input  logic                iclk,
    input  logic                irst_n,
    mux41_rr_arbiter_if.slave   bus
);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state;
    logic [1:0]   last;
    logic [CW-1:0] cnt;
    logic [3:0]   grant_r;
    logic [1:0]   s_r;
    logic [W-1:0] z_r;
    logic         valid_r;

    logic [1:0]   winner;
    logic [W-1:0] sel_word;
    logic         lock_hold;
    logic         end_grant;

    // Scan from last+4 down to last+1 so the nearest successor of last wins.
    function automatic logic [1:0] pick(input logic [1:0] from, input logic [3:0] req);
        logic [1:0] idx;
        pick = from;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (req[idx]) pick = idx;
        end
    endfunction

    assign winner = pick(last, bus.ireq);

    always_comb begin
        sel_word = bus.ic0;
        case (s_r)
            2'd1:    sel_word = bus.ic1;
            2'd2:    sel_word = bus.ic2;
            2'd3:    sel_word = bus.ic3;
            default: sel_word = bus.ic0;
        endcase
    end

`ifdef MUX41_ARB_LOCK_EN
    assign lock_hold = bus.ilock & bus.ireq[s_r];
`else
    assign lock_hold = 1'b0;
`endif

    assign end_grant = !bus.ireq[s_r] || ((cnt == '0) && !lock_hold);

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            state   <= IDLE;
            last    <= 2'd3;
            cnt     <= '0;
            grant_r <= 4'b0000;
            s_r     <= 2'd0;
            z_r     <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (|bus.ireq) begin
                        grant_r <= 4'b0001 << winner;
                        s_r     <= winner;
                        last    <= winner;
                        cnt     <= CNT_LOAD;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.ireq[s_r]) begin
                        z_r     <= sel_word;
                        valid_r <= 1'b1;
                    end else begin
                        valid_r <= 1'b0;
                    end
                    if (end_grant) begin
                        // last equals s_r here, so winner already rotates past the finished grant.
                        if (|bus.ireq) begin
                            grant_r <= 4'b0001 << winner;
                            s_r     <= winner;
                            last    <= winner;
                            cnt     <= CNT_LOAD;
                        end else begin
                            grant_r <= 4'b0000;
                            state   <= IDLE;
                        end
                    end else if (!lock_hold) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ogrant = grant_r;
    assign bus.os     = s_r;
    assign bus.oz     = z_r;
    assign bus.ovalid = valid_r;
    assign bus.obusy  = (state == BUSY);
endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// tb/tb_mux41_rr_arbiter.sv - directed table-driven bench for mux41_rr_arbiter (W=4, HOLD=4)
module tb_mux41_rr_arbiter;
    logic iclk;
    logic irst_n;
    int   n_cmp;
    int   n_bad;

    mux41_rr_arbiter_if #(.W(4)) bus();

    mux41_rr_arbiter #(.W(4), .HOLD(4)) dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .bus    (bus.slave)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] s;
        logic [3:0] z;
        logic       v;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_n, input logic [3:0] req, input logic [3:0] grant,
                       input logic [1:0] s, input logic [3:0] z, input logic v, input logic b);
        vec_t e;
        e.rst_n = rst_n; e.req = req; e.grant = grant; e.s = s; e.z = z; e.v = v; e.b = b;
        tbl.push_back(e);
    endtask

    task automatic cyc(input logic rst_n, input logic [3:0] req);
        irst_n   = rst_n;
        bus.ireq = req;
        @(posedge iclk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] grant, input logic [1:0] s,
                         input logic [3:0] z, input logic v, input logic b);
        logic [11:0] got;
        logic [11:0] exp;
        got = {bus.ogrant, bus.os, bus.oz, bus.ovalid, bus.obusy};
        exp = {grant, s, z, v, b};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got grant=%b s=%0d z=%h v=%b b=%b, expected grant=%b s=%0d z=%h v=%b b=%b",
                     name, bus.ogrant, bus.os, bus.oz, bus.ovalid, bus.obusy, grant, s, z, v, b);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        irst_n = 1'b0;
        bus.ireq = 4'b0000;
        bus.ic0 = 4'd1;
        bus.ic1 = 4'd2;
        bus.ic2 = 4'd3;
        bus.ic3 = 4'd4;
`ifdef MUX41_ARB_LOCK_EN
        bus.ilock = 1'b0;
`endif

        // reset with all requesting, then fairness rotation 0,1,2,3,0
        add(0, 4'hF, 4'b0000, 0, 4'd0, 0, 0);
        add(0, 4'hF, 4'b0000, 0, 4'd0, 0, 0);
        add(1, 4'hF, 4'b0001, 0, 4'd0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 4'hF, 4'b0001, 0, 4'd1, 1, 1);
        add(1, 4'hF, 4'b0010, 1, 4'd1, 1, 1);
        for (int i = 0; i < 3; i++) add(1, 4'hF, 4'b0010, 1, 4'd2, 1, 1);
        add(1, 4'hF, 4'b0100, 2, 4'd2, 1, 1);
        for (int i = 0; i < 3; i++) add(1, 4'hF, 4'b0100, 2, 4'd3, 1, 1);
        add(1, 4'hF, 4'b1000, 3, 4'd3, 1, 1);
        for (int i = 0; i < 3; i++) add(1, 4'hF, 4'b1000, 3, 4'd4, 1, 1);
        add(1, 4'hF, 4'b0001, 0, 4'd4, 1, 1);
        // reset again, single requester 2 with full grant, regrant, then drop
        add(0, 4'h0, 4'b0000, 0, 4'd0, 0, 0);
        add(1, 4'h4, 4'b0100, 2, 4'd0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 4'h4, 4'b0100, 2, 4'd3, 1, 1);
        add(1, 4'h4, 4'b0100, 2, 4'd3, 1, 1);
        add(1, 4'h0, 4'b0000, 2, 4'd3, 0, 0);
        add(1, 4'h0, 4'b0000, 2, 4'd3, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst_n, tbl[i].req);
            check($sformatf("vec%0d", i), tbl[i].grant, tbl[i].s, tbl[i].z, tbl[i].v, tbl[i].b);
        end

        // early release of requester 1 while requester 3 waits
        cyc(0, 4'b0000);
        check("er_reset", 4'b0000, 0, 4'd0, 0, 0);
        cyc(1, 4'b1010);
        check("er_grant1", 4'b0010, 1, 4'd0, 0, 1);
        cyc(1, 4'b1010);
        check("er_cap1", 4'b0010, 1, 4'd2, 1, 1);
        cyc(1, 4'b1010);
        check("er_cap2", 4'b0010, 1, 4'd2, 1, 1);
        cyc(1, 4'b1000);
        check("er_switch", 4'b1000, 3, 4'd2, 0, 1);
        cyc(1, 4'b1000);
        check("er_cap3", 4'b1000, 3, 4'd4, 1, 1);

        // reset in the third cycle of a requester 2 grant
        cyc(0, 4'b0000);
        cyc(1, 4'b0100);
        check("mr_grant2", 4'b0100, 2, 4'd0, 0, 1);
        cyc(1, 4'b0100);
        cyc(1, 4'b0100);
        check("mr_third", 4'b0100, 2, 4'd3, 1, 1);
        cyc(0, 4'b0100);
        check("mr_reset", 4'b0000, 0, 4'd0, 0, 0);
        cyc(1, 4'b1100);
        check("mr_prio2", 4'b0100, 2, 4'd0, 0, 1);

`ifdef MUX41_ARB_LOCK_EN
        // lock extends requester 0 well past HOLD, then 4 more edges to expiry
        cyc(0, 4'b0000);
        bus.ilock = 1'b1;
        cyc(1, 4'b0011);
        check("lk_grant0", 4'b0001, 0, 4'd0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 4'b0011);
            check($sformatf("lk_hold%0d", i), 4'b0001, 0, 4'd1, 1, 1);
        end
        bus.ilock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 4'b0011);
            check($sformatf("lk_tail%0d", i), 4'b0001, 0, 4'd1, 1, 1);
        end
        cyc(1, 4'b0011);
        check("lk_expire", 4'b0010, 1, 4'd1, 1, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mux41_rr_arbiter.md
# mux41_rr_arbiter

- Round-robin arbiter and sequencer that shares one 4:1, W-bit multiplexer among four requesters.
- Grants the mux to one requester at a time for a bounded number of cycles.
- Drives the mux select, and registers the selected word with a valid strobe for the downstream consumer.
- Sits directly in front of the 4:1 mux datapath, replacing static select-line stimulus with request-driven scheduling.

## Interface
Parameters:
- W, 4, data width of each requester word and of oz.
- HOLD, 4, maximum grant length in cycles; legal range 1..16.

Ports:
- iclk  input  1  clock; all state updates on rising edge.
- irst_n  input  1  reset; synchronous and active-low.
- ireq  input  4  request per requester; bit k belongs to ick.
- ic0, ic1, ic2, ic3  input  W  requester data words.
- ogrant  output  4  one-hot grant; 0 when idle.
- os  output  2  select index of current/last grant.
- oz  output  W  registered selected word.
- ovalid  output  1  oz carries a newly captured granted word.
- obusy  output  1  grant in progress.

## Operation
- Two states: IDLE and BUSY.
- Internal state:
  - 2-bit pointer last, holding the index of the most recently granted requester.
  - Hold counter cnt, of width clog2(HOLD), minimum 1.
- Winner selection: scan indices last+1, last+2, last+3, last+4 (mod 4). The first with ireq set wins. The last-granted requester therefore has lowest priority, but still wins if it is the sole requester.
- IDLE:
  - If any ireq bit is set, on the edge: ogrant is set one-hot to the winner, os becomes the winner, last becomes the winner, cnt becomes HOLD-1, and the state moves to BUSY.
  - Otherwise hold.
- BUSY, every edge:
  - If ireq[os]=1: oz becomes ic[os] and ovalid becomes 1. Otherwise ovalid becomes 0 and oz holds.
  - The grant ends when cnt==0 or ireq[os]==0. Otherwise cnt decrements.
- End of grant (same edge):
  - If any ireq bit is set, re-arbitrate immediately against the updated last and stay in BUSY. Re-arbitration is back-to-back, with no idle cycle.
  - Otherwise ogrant becomes 0 and the state moves to IDLE. os holds.
- Outside BUSY, ovalid becomes 0 and oz holds.
- Changes on ireq bits other than the granted one are ignored until the grant ends.
- obusy = (state==BUSY).

## Timing
- Reset values, applied at any edge where irst_n=0, including mid-grant:
  - ogrant=0, os=0, oz=0, ovalid=0, obusy=0.
  - state=IDLE, cnt=0, last=3, so requester 0 has first priority.
- Request-to-grant latency: ireq sampled high at edge N gives ogrant and os valid after edge N.
- Data latency: oz and ovalid lag ogrant by one cycle.
- A full grant gives ogrant high for exactly HOLD cycles and HOLD ovalid pulses.
- Early release: when the granted ireq is low at edge M, the grant ends at M and that cycle is not captured.
- HOLD=1: every grant lasts one cycle, giving pure per-cycle round robin.
- Simultaneous events:
  - An end of grant together with new requests re-arbitrates on the same edge.
  - Reset overrides everything.
- ic inputs are sampled only at edges during BUSY. They need no stability outside the granted index.

## Configuration
- MUX41_ARB_LOCK_EN defined:
  - Adds port ilock, input, 1 bit.
  - While BUSY and ireq[os]=1 and ilock=1, cnt does not decrement, and a cnt==0 expiry is suppressed. The grant extends until ilock falls.
  - ilock has no effect in IDLE.
  - Early release on ireq[os]=0 still applies.
- Undefined: no ilock port, and grants always expire after HOLD cycles.

## Test plan
- Reset: irst_n=0 for 2 cycles with ireq=4'b1111 -> all outputs 0. After release, next edge gives ogrant=4'b0001 and os=0.
- Single requester, HOLD=4: ireq=4'b0100, ic2=4'b0011 -> ogrant=4'b0100 and os=2 for 4 cycles. ovalid is high for 4 cycles, one cycle later, with oz=4'b0011. Then ogrant=0 and obusy=0 if ireq drops, or a regrant to 2 if it stays high.
- Fairness: ireq=4'b1111, with ic0..ic3 = 1, 2, 3, 4 -> grants 0, 1, 2, 3, 0, each 4 cycles, back-to-back. oz sequence: 1×4, 2×4, 3×4, 4×4. obusy is never low.
- Early release: requester 1 granted; drop ireq[1] after 2 cycles while ireq[3]=1 -> ogrant switches to 4'b1000 on that edge. Exactly 2 ovalid pulses with oz=2.
- Reset mid-grant: assert irst_n=0 during the third cycle of a requester 2 grant -> all outputs 0 after that edge. With ireq=4'b1100 after release, requester 2 is granted first, because last=3.
- MUX41_ARB_LOCK_EN: requester 0 granted, ilock=1 for 10 cycles -> ogrant=4'b0001 for 10+ cycles. Expiry occurs 3 cycles after ilock falls, on the edge where cnt==0, with ovalid continuous throughout.
